matrix_decoder: RTL and testbench



---
 rtl/matrix_decoder_pkg.sv | 20 ++
 rtl/matrix_unpermute.sv | 17 +
 rtl/matrix_decoder.sv | 123 ++++++++++++
 tb/tb_matrix_decoder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/matrix_decoder_pkg.sv
// Shared definitions for the 5x5 bit-matrix slice decoder.
// Build option: PARITY_CHECK_EN adds a trailing even-parity bit per slice.
package matrix_decoder_pkg;

  localparam int unsigned SLICE_W = 25;
  localparam int unsigned ROW_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Encoded bit index that holds plain bit (row y, column x): undoes the row rotation.
  function automatic int unsigned decode_idx(input int unsigned y, input int unsigned x);
    return ROW_W * y + ((x + ROW_W - y) % ROW_W);
  endfunction

endpackage

// File: rtl/matrix_unpermute.sv
// Combinational row-unrotate of one encoded 25-bit slice.
// Build option: none (PARITY_CHECK_EN does not affect this block).
module matrix_unpermute
  import matrix_decoder_pkg::*;
(
  input  logic [SLICE_W-1:0] enc,
  output logic [SLICE_W-1:0] plain
);

  // Pure wiring: each plain bit picks its rotated source bit in the same row.
  for (genvar y = 0; y < ROW_W; y++) begin : g_row
    for (genvar x = 0; x < ROW_W; x++) begin : g_col
      assign plain[ROW_W*y + x] = enc[decode_idx(y, x)];
    end
  end

endmodule

// File: rtl/matrix_decoder.sv
// Serial-in 5x5 matrix slice decoder with valid/ready output and frame control.
// Build option: PARITY_CHECK_EN -> 26-bit slices with even parity, par_err reported.
module matrix_decoder
  import matrix_decoder_pkg::*;
#(
  parameter int unsigned NUM_SLICES  = 64,
  parameter int unsigned SLICE_CNT_W = 7
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sin,
  input  logic               sin_valid,
  output logic               sin_ready,
  output logic [SLICE_W-1:0] dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               par_err,
  output logic               busy,
  output logic               done
);

  localparam int unsigned BIT_CNT_W = 5;
  localparam logic [BIT_CNT_W-1:0]   LAST_BIT   = BIT_CNT_W'(SLICE_W - 1);
  localparam logic [SLICE_CNT_W-1:0] LAST_SLICE = SLICE_CNT_W'(NUM_SLICES - 1);

  state_t                 state;
  logic [SLICE_W-1:0]     shreg;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [SLICE_CNT_W-1:0] slice_cnt;
`ifdef PARITY_CHECK_EN
  logic                   par_q;
`endif

  // Serial input is accepted only while collecting data or parity bits.
  assign sin_ready = (state == ST_SHIFT) || (state == ST_PAR);

  // Decoded slice is a pure function of the shift register.
  matrix_unpermute u_unpermute (
    .enc   (shreg),
    .plain (dout)
  );

`ifdef PARITY_CHECK_EN
  assign par_err = par_q;
`else
  assign par_err = 1'b0;
`endif

  // Frame FSM, deserialiser and counters with registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      slice_cnt  <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_q      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_SHIFT;
            bit_cnt   <= '0;
            slice_cnt <= '0;
            busy      <= 1'b1;
`ifdef PARITY_CHECK_EN
            par_q     <= 1'b0;
`endif
          end
        end
        ST_SHIFT: begin
          if (sin_valid) begin
            shreg   <= {shreg[SLICE_W-2:0], sin};
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            if (bit_cnt == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
              state      <= ST_PAR;
`else
              state      <= ST_OUT;
              dout_valid <= 1'b1;
`endif
            end
          end
        end
`ifdef PARITY_CHECK_EN
        ST_PAR: begin
          if (sin_valid) begin
            par_q      <= (^shreg) ^ sin;
            state      <= ST_OUT;
            dout_valid <= 1'b1;
          end
        end
`endif
        ST_OUT: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
            if (slice_cnt == LAST_SLICE) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= ST_SHIFT;
              slice_cnt <= slice_cnt + SLICE_CNT_W'(1);
              bit_cnt   <= '0;
`ifdef PARITY_CHECK_EN
              par_q     <= 1'b0;
`endif
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_decoder.sv
// Directed and randomised checks of matrix_decoder (single-slice and 64-slice frames).
// Build option: PARITY_CHECK_EN must match the RTL build.
module tb_matrix_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic        sin, sin_valid, dout_ready;
  logic        sel_b;

  logic        rdy_a, dv_a, pe_a, busy_a, done_a;
  logic [24:0] dout_a;
  logic        rdy_b, dv_b, pe_b, busy_b, done_b;
  logic [24:0] dout_b;

  int checks = 0;
  int errors = 0;
  int done_cnt_b = 0;

  always #5 clk = ~clk;

  matrix_decoder #(.NUM_SLICES(1), .SLICE_CNT_W(7)) u_one (
    .clk(clk), .rst(rst), .start(start_a), .sin(sin), .sin_valid(sin_valid),
    .sin_ready(rdy_a), .dout(dout_a), .dout_valid(dv_a), .dout_ready(dout_ready),
    .par_err(pe_a), .busy(busy_a), .done(done_a)
  );

  matrix_decoder #(.NUM_SLICES(64), .SLICE_CNT_W(7)) u_dut (
    .clk(clk), .rst(rst), .start(start_b), .sin(sin), .sin_valid(sin_valid),
    .sin_ready(rdy_b), .dout(dout_b), .dout_valid(dv_b), .dout_ready(dout_ready),
    .par_err(pe_b), .busy(busy_b), .done(done_b)
  );

  // Count done pulses from the 64-slice instance.
  always @(posedge clk) begin
    if (rst && done_b) done_cnt_b <= done_cnt_b + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Encoder model: encoded (y,x) takes plain (y,(x+y) mod 5).
  function automatic logic [24:0] encode(input logic [24:0] p);
    logic [24:0] e;
    e = '0;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        e[5*y + x] = p[5*y + ((x + y) % 5)];
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the bit is accepted.
  task automatic send_bit(input logic b);
    int guard;
    guard = 0;
    sin = b;
    sin_valid = 1'b1;
    while (!(sel_b ? rdy_b : rdy_a) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("send_timeout", 32'd1, 32'd0);
    @(negedge clk);
    sin_valid = 1'b0;
  endtask

  task automatic send_slice(input logic [24:0] enc, input logic par, input int max_gap);
    for (int i = 24; i >= 0; i--) begin
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send_bit(enc[i]);
    end
`ifdef PARITY_CHECK_EN
    send_bit(par);
`else
    if (par === 1'bx) sin = 1'b0;
`endif
  endtask

  task automatic pulse_start(input logic which_b);
    if (which_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic handshake();
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, "_dout"},  32'(dout_a), 32'd0);
    check({tag, "_dv"},    32'(dv_a),   32'd0);
    check({tag, "_rdy"},   32'(rdy_a),  32'd0);
    check({tag, "_busy"},  32'(busy_a), 32'd0);
    check({tag, "_done"},  32'(done_a), 32'd0);
    check({tag, "_perr"},  32'(pe_a),   32'd0);
  endtask

  initial begin
    logic [24:0] p, e;
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
    sin = 1'b0; sin_valid = 1'b0; dout_ready = 1'b0; sel_b = 1'b0;

    // Power-on reset.
    repeat (3) @(negedge clk);
    check_idle_a("por");
    check("por_busy_b", 32'(busy_b), 32'd0);
    check("por_dv_b",   32'(dv_b),   32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Reset held 3 cycles in the middle of a slice.
    pulse_start(1'b0);
    check("start_busy", 32'(busy_a), 32'd1);
    check("start_rdy",  32'(rdy_a),  32'd1);
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_a("midrst");
    rst = 1'b1;
    @(negedge clk);
    check("midrst_start_ign", 32'(rdy_a), 32'd0);

    // Clean single-slice frame: 0x0000020 -> 0x0000040.
    pulse_start(1'b0);
    check("f1_perr_clr", 32'(pe_a), 32'd0);
    send_slice(25'h0000020, 1'b1, 0);
    check("f1_dv",   32'(dv_a),   32'd1);
    check("f1_dout", 32'(dout_a), 32'h0000040);
    check("f1_perr", 32'(pe_a),   32'd0);
    check("f1_rdy",  32'(rdy_a),  32'd0);
    handshake();
    check("f1_done", 32'(done_a), 32'd1);
    check("f1_busy", 32'(busy_a), 32'd0);
    check("f1_dv0",  32'(dv_a),   32'd0);
    @(negedge clk);
    check("f1_done_1cyc", 32'(done_a), 32'd0);

    // 0x1000000 -> 0x0800000, held with dout_ready low while sin_valid is driven.
    pulse_start(1'b0);
    send_slice(25'h1000000, 1'b1, 1);
    check("f2_dout", 32'(dout_a), 32'h0800000);
    sin = 1'b1;
    sin_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("f2_hold_dout", 32'(dout_a), 32'h0800000);
      check("f2_hold_dv",   32'(dv_a),   32'd1);
      check("f2_hold_rdy",  32'(rdy_a),  32'd0);
    end
    sin_valid = 1'b0;
    handshake();
    check("f2_done", 32'(done_a), 32'd1);
    check("f2_busy", 32'(busy_a), 32'd0);

`ifdef PARITY_CHECK_EN
    // Wrong parity bit flags an error; it clears on the next frame.
    pulse_start(1'b0);
    send_slice(25'h0000020, 1'b0, 0);
    check("par_bad_err",  32'(pe_a),   32'd1);
    check("par_bad_dout", 32'(dout_a), 32'h0000040);
    handshake();
    pulse_start(1'b0);
    check("par_clr", 32'(pe_a), 32'd0);
    send_slice(25'h0000020, 1'b1, 0);
    check("par_ok_err", 32'(pe_a), 32'd0);
    handshake();
`endif

    // 64-slice frame with random data, gaps, and stray start pulses.
    sel_b = 1'b1;
    pulse_start(1'b1);
    for (int s = 0; s < 64; s++) begin
      p = 25'($urandom);
      e = encode(p);
      if (s % 16 == 5) pulse_start(1'b1);
      send_slice(e, ^e, 2);
      check("rnd_dv",   32'(dv_b),   32'd1);
      check("rnd_dout", 32'(dout_b), 32'(p));
      check("rnd_perr", 32'(pe_b),   32'd0);
      if (s % 16 == 9) pulse_start(1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      handshake();
      if (s < 63) begin
        check("rnd_busy", 32'(busy_b), 32'd1);
        check("rnd_nodone", 32'(done_b), 32'd0);
      end
    end
    check("rnd_done", 32'(done_b), 32'd1);
    check("rnd_busy_end", 32'(busy_b), 32'd0);
    repeat (5) @(negedge clk);
    check("rnd_done_cnt", 32'(done_cnt_b), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
